// File: rtl/dbg_cap_pkg.sv
// Shared definitions for the debug-capture write controller.
//   - Default RAM geometry (depth, address width, sample width).
//   - Capture FSM state encoding (3 bits).
package dbg_cap_pkg;

  localparam int RAM_DEPTH_DEF  = 4096;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE   = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

endpackage

// File: rtl/dbg_cap_wr_ctrl_if.sv
// Write port of the debug sample RAM (single write port, 1R1W RAM).
//   master : capture controller, drives cs/wr/addr/din
//   slave  : RAM write port (or a monitor)
interface dbg_cap_wr_ctrl_if
  import dbg_cap_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  ram_cs;
  logic                  ram_wr;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;

  modport master (output ram_cs, ram_wr, ram_addr, ram_din);
  modport slave  (input  ram_cs, ram_wr, ram_addr, ram_din);
endinterface

// File: rtl/dbg_cap_decim.sv
// Sample-accept gate used when decimation is enabled.
//   clk, rst_n : capture clock, async active-low reset
//   clr        : restarts the decimation phase (pulsed on arm)
//   smp_vld    : raw sample valid
//   decim      : accept one out of every (decim+1) valid samples
//   accept     : strobe, high on the accepted valid sample
module dbg_cap_decim (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       smp_vld,
  input  logic [7:0] decim,
  output logic       accept
);
  logic [7:0] cnt;

  // The (decim+1)-th valid sample after a clear is the first one accepted.
  assign accept = smp_vld && (cnt == decim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (clr)     cnt <= '0;
    else if (smp_vld) cnt <= accept ? 8'd0 : cnt + 8'd1;
  end
endmodule

// File: rtl/dbg_cap_wr_ctrl.sv
// Write-side capture controller for the debug sample RAM.
// Writes an ADC sample stream into a circular buffer, keeps cfg_pre_len
// samples ahead of the trigger and cfg_post_len samples from the trigger
// on (trigger sample included), then stops and reports done.
//   clk, rst_n          : capture clock, async active-low reset
//   cfg_arm/cfg_abort   : start / cancel a capture (abort wins)
//   cfg_pre_len/post_len: capture window, latched on arm
//   cfg_decim           : decimation ratio (only with DBG_CAP_DECIM_EN)
//   trig_in, smp_vld, smp_data : sample stream and trigger level
//   ram                 : RAM write port (registered, one cycle after accept)
//   sts_*               : busy, done, trigger address, wrapped flag
// Optional feature macro: DBG_CAP_DECIM_EN (adds cfg_decim and the
// dbg_cap_decim accept gate).
module dbg_cap_wr_ctrl
  import dbg_cap_pkg::*;
#(
  parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic [ADDR_WIDTH-1:0] cfg_pre_len,
  input  logic [ADDR_WIDTH-1:0] cfg_post_len,
`ifdef DBG_CAP_DECIM_EN
  input  logic [7:0]            cfg_decim,
`endif
  input  logic                  trig_in,
  input  logic                  smp_vld,
  input  logic [DATA_WIDTH-1:0] smp_data,
  dbg_cap_wr_ctrl_if.master     ram,
  output logic                  sts_busy,
  output logic                  sts_done,
  output logic [ADDR_WIDTH-1:0] sts_trig_addr,
  output logic                  sts_wrap
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  cap_state_t            state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, pre_cnt, post_cnt, pre_len_q, post_len_q;
  logic [ADDR_WIDTH-1:0] pre_cnt_inc, post_cnt_inc;
  logic                  accept, wr_en, trig_hit, arm_go;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] din_p1;

`ifdef DBG_CAP_DECIM_EN
  logic [7:0] decim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      decim_q <= '0;
    else if (arm_go) decim_q <= cfg_decim;
  end

  dbg_cap_decim u_decim (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cfg_arm),
    .smp_vld (smp_vld),
    .decim   (decim_q),
    .accept  (accept)
  );
`else
  assign accept = smp_vld;
`endif

  assign arm_go       = cfg_arm && !cfg_abort;
  assign pre_cnt_inc  = pre_cnt + ONE;
  assign post_cnt_inc = post_cnt + ONE;

  // Next state and per-cycle write decision. The arm/abort cycle never
  // writes its own sample.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    trig_hit  = 1'b0;
    if (cfg_abort) begin
      state_nxt = IDLE;
    end else if (cfg_arm) begin
      state_nxt = (cfg_pre_len == '0) ? ARMED : PRE;
    end else if (accept) begin
      case (state)
        PRE: begin
          wr_en = 1'b1;
          if (pre_cnt_inc == pre_len_q) state_nxt = ARMED;
        end
        ARMED: begin
          wr_en = 1'b1;
          if (trig_in) begin
            trig_hit  = 1'b1;
            state_nxt = (post_len_q <= ONE) ? DONE : POST;
          end
        end
        POST: begin
          wr_en = 1'b1;
          if (post_cnt_inc == post_len_q) state_nxt = DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
      pre_len_q     <= '0;
      post_len_q    <= '0;
      sts_trig_addr <= '0;
      sts_wrap      <= 1'b0;
      sts_done      <= 1'b0;
      vld_p1        <= 1'b0;
      addr_p1       <= '0;
      din_p1        <= '0;
    end else begin
      state  <= state_nxt;
      // stage p1: registered RAM write port
      vld_p1 <= wr_en;
      if (wr_en) begin
        addr_p1 <= ptr;
        din_p1  <= smp_data;
        ptr     <= ptr + ONE;
        if (ptr == LAST_ADDR) sts_wrap <= 1'b1;
      end
      if (arm_go) begin
        ptr        <= '0;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        sts_done   <= 1'b0;
        sts_wrap   <= 1'b0;
        pre_len_q  <= cfg_pre_len;
        post_len_q <= cfg_post_len;
      end
      if (wr_en && state == PRE) pre_cnt <= pre_cnt_inc;
      if (trig_hit) begin
        sts_trig_addr <= ptr;
        post_cnt      <= ONE;
      end else if (wr_en && state == POST) begin
        post_cnt <= post_cnt_inc;
      end
      if (state_nxt == DONE && state != DONE) sts_done <= 1'b1;
    end
  end

  assign sts_busy     = (state != IDLE) && (state != DONE);
  assign ram.ram_cs   = vld_p1;
  assign ram.ram_wr   = vld_p1;
  assign ram.ram_addr = addr_p1;
  assign ram.ram_din  = din_p1;

endmodule
